seq_shift_unit: RTL and testbench

//  Multi-cycle shifter: loads a WIDTH-bit operand, then shifts or rotates it one bit per clock
//  for a requested number of steps, under a start/busy/done handshake.

---
 rtl/seq_shift_unit.sv | 78 +++++++
 tb/tb_seq_shift_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shifter that loads an operand and then shifts or rotates it one bit per clock.
// A start/busy/done handshake sequences each operation; every output comes straight from a flop.
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept, shifting, rot, arith, fill_l, fill_r;
    logic [WIDTH-1:0] step_q;
    logic             step_so;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            q_q     <= '0;
            so_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = (state_q == IDLE)  ? (start ? ((amount != '0) ? SHIFT : DONE) : IDLE) :
                  (state_q == SHIFT) ? ((cnt_q == CNT_W'(1)) ? DONE : SHIFT) : IDLE;
    end
    // Mode 11 behaves as logical; arithmetic only differs from logical when shifting right.
    always_comb begin
        accept   = (state_q == IDLE) && start;
        shifting = (state_q == SHIFT);
        rot      = (mode_q == 2'b10);
        arith    = (mode_q == 2'b01);
        fill_l   = rot & q_q[WIDTH-1];
        fill_r   = rot ? q_q[0] : (arith & q_q[WIDTH-1]);
        step_q   = dir_q ? {fill_r, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fill_l};
        step_so  = dir_q ? q_q[0] : q_q[WIDTH-1];
        q_d      = accept ? d      : shifting ? step_q           : q_q;
        so_d     = accept ? 1'b0   : shifting ? step_so          : so_q;
        cnt_d    = accept ? amount : shifting ? cnt_q - CNT_W'(1) : cnt_q;
        dir_d    = accept ? dir    : dir_q;
        mode_d   = accept ? mode   : mode_q;
        busy_d   = (state_d == SHIFT);
        done_d   = (state_d == DONE);
    end
    assign q          = q_q;
    assign serial_out = so_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed and random operations checked against a scoreboard of
// model-predicted results, latencies and busy lengths.
module tb_seq_shift_unit;
    logic       clk = 1'b0;
    logic       reset, start, dir;
    logic [1:0] mode;
    logic [3:0] amount;
    logic [7:0] d, q;
    logic       serial_out, busy, done;
    int         total = 0;
    int         bad = 0;

    typedef struct {logic [7:0] q; logic so; int amt;} exp_t;
    exp_t sb[$];

    seq_shift_unit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .mode(mode),
        .amount(amount), .d(d), .q(q), .serial_out(serial_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Whole-word model: shifts by n at once instead of stepping.
    function automatic exp_t model(input logic [7:0] dv, input logic dr, input logic [1:0] md, input int n);
        exp_t r;
        logic [31:0] e;
        int m;
        r.amt = n;
        if (md == 2'b10) begin
            m = n % 8;
            if (!dr) begin e = {16'b0, dv, dv} << m; r.q = e[15:8]; end
            else begin e = {16'b0, dv, dv} >> m; r.q = e[7:0]; end
            r.so = (n == 0) ? 1'b0 : (dr ? r.q[7] : r.q[0]);
        end else if (dr) begin
            e = (md == 2'b01) ? unsigned'($signed({{16{dv[7]}}, dv, 8'b0}) >>> n) : ({16'b0, dv, 8'b0} >> n);
            r.q = e[15:8];
            r.so = e[7];
        end else begin
            e = {24'b0, dv} << n;
            r.q = e[7:0];
            r.so = e[8];
        end
        return r;
    endfunction

    // Called just after the accepting edge; scrambles inputs while the operation runs.
    task automatic wait_done(input bit keep);
        int n = 0;
        int b = 0;
        bit got = 0;
        exp_t e;
        repeat (40) begin
            @(negedge clk);
            n++;
            if (busy) b++;
            if (!keep) start = 1'b0;
            d = 8'($urandom); dir = 1'($urandom); mode = 2'($urandom); amount = 4'($urandom);
            if (done) begin got = 1; break; end
        end
        if (!got) begin
            chk("timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk("unexpected_done", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("q", q, e.q);
            chk("serial_out", serial_out, e.so);
            chk("latency", n, e.amt + 1);
            chk("busy_cycles", b, e.amt);
        end
    endtask

    task automatic run_op(input logic [7:0] dv, input logic dr, input logic [1:0] md, input logic [3:0] am, input bit keep);
        @(negedge clk);
        d = dv; dir = dr; mode = md; amount = am; start = 1'b1;
        sb.push_back(model(dv, dr, md, int'(am)));
        @(posedge clk);
        wait_done(keep);
    endtask

    initial begin
        bit seen;
        reset = 1'b1; start = 1'b0; dir = 1'b0; mode = 2'b00; amount = 4'd0; d = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_so", serial_out, 0);
        reset = 1'b0;
        run_op(8'hB4, 0, 2'b00, 4'd3, 0);
        chk("t1_q_const", q, 8'hA0);
        run_op(8'h96, 1, 2'b01, 4'd2, 0);
        @(negedge clk);
        chk("t2_done_width", done, 0);
        run_op(8'h81, 1, 2'b10, 4'd9, 0);
        chk("t3_q_const", q, 8'hC0);
        run_op(8'h5A, 0, 2'b00, 4'd0, 0);
        chk("t4_q_const", q, 8'h5A);
        run_op(8'h5A, 0, 2'b00, 4'd15, 0);
        run_op(8'h80, 1, 2'b01, 4'd12, 0);
        run_op(8'h6D, 0, 2'b10, 4'd10, 0);
        run_op(8'hF1, 1, 2'b11, 4'd5, 0);
        run_op(8'hC7, 0, 2'b01, 4'd1, 0);
        // start held through busy and done: the first operand wins, then one idle cycle
        run_op(8'hC3, 0, 2'b10, 4'd4, 1);
        d = 8'h0F; dir = 1'b1; mode = 2'b00; amount = 4'd2;
        @(negedge clk);
        chk("t5_idle_done", done, 0);
        chk("t5_idle_busy", busy, 0);
        sb.push_back(model(8'h0F, 1, 2'b00, 2));
        @(posedge clk);
        wait_done(0);
        // reset in the middle of a long operation
        @(negedge clk);
        d = 8'hFF; dir = 1'b0; mode = 2'b10; amount = 4'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("t6_q", q, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_so", serial_out, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("t6_no_late_done", seen, 0);
        run_op(8'h3C, 1, 2'b01, 4'd3, 0);
        for (int i = 0; i < 6; i++)
            run_op(8'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 0);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
